// File: rtl/dmem_pkg.sv
// ----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory controller.
//   - dmemState_e : controller state (IDLE, RD, WR, DONE)
//   - ALIGN_MASK  : required value of the byte-offset bits of a word address
//   - DEF_*       : default address width, data width and bus timeout
//   - cntWidth()  : width of a counter that must hold 0 .. terminal-1
// ----------------------------------------------------------------------------
package dmem_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;

  // A word access is legal only when the two byte-offset bits match this.
  localparam logic [1:0] ALIGN_MASK = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dmemState_e;

  // Bits needed to count 0 .. limit-1 (at least one bit).
  function automatic int cntWidth(input int limit);
    return (limit <= 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/dmem_timer.sv
// ----------------------------------------------------------------------------
// dmem_timer
// Clear/enable up-counter with a terminal-count flag, used as the bus-wait
// timeout of dmem_ctrl. The counter stops at TERMINAL so it never wraps.
// Ports:
//   clk  in  system clock, rising edge
//   rst  in  asynchronous active-high reset
//   clr  in  synchronous clear (has priority over en)
//   en   in  count enable
//   tc   out high while the count equals TERMINAL
// ----------------------------------------------------------------------------
module dmem_timer #(
  parameter int WIDTH    = 8,
  parameter int TERMINAL = 254
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/dmem_ctrl.sv
// ----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory controller between the single-cycle CPU memory port and a
// variable-latency req/ack backing memory. Each legal CPU load/store becomes
// one bus transfer; the CPU is stalled until it completes. Misaligned and
// read+write-at-once requests are refused and set a sticky error, as does a
// transfer that sees no mem_ack within TIMEOUT request cycles.
//
// Optional feature (macro DMEM_WBUF_EN): one-entry posted-write buffer. A
// store issued while idle retires immediately and drains through WR in the
// background; a later access that needs the bus waits for the drain.
//
// Ports:
//   clk, rst            clock (rising edge), async active-high reset
//   cpu_addr/cpu_wdata  CPU byte address and store data
//   cpu_rd_en/cpu_wr_en CPU load / store request (held while cpu_stall)
//   cpu_rdata           load data, valid in the retire (DONE) cycle
//   cpu_stall           CPU must hold PC and requests while high
//   mem_err             sticky error flag, cleared only by rst
//   mem_req/mem_we      bus request and direction (1 = write)
//   mem_addr/mem_wdata  word-aligned bus address and write data
//   mem_ack/mem_rdata   bus completion strobe and read data
// ----------------------------------------------------------------------------
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT   // must be >= 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rd_en,
  input  logic              cpu_wr_en,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmemState_e state;

  logic reqAny;
  logic reqBad;
  logic reqGood;
  logic inXfer;
  logic timerTc;

  assign reqAny  = cpu_rd_en | cpu_wr_en;
  // Asking for both directions at once is refused like a misaligned access.
  assign reqBad  = reqAny &&
                   ((cpu_addr[1:0] != ALIGN_MASK) || (cpu_rd_en && cpu_wr_en));
  assign reqGood = reqAny && !reqBad;
  assign inXfer  = (state == RD) || (state == WR);

  // Wait counter: held at zero outside a transfer, so it starts from zero on
  // every entry to RD/WR; it only advances in cycles without an ack.
  dmem_timer #(
    .WIDTH    (cntWidth(TIMEOUT)),
    .TERMINAL (TIMEOUT - 1)
  ) uTimer (
    .clk (clk),
    .rst (rst),
    .clr (!inXfer),
    .en  (inXfer && !mem_ack),
    .tc  (timerTc)
  );

  // The stall must rise in the same cycle the request appears, so it is
  // decoded from state and the live request rather than registered.
  always_comb begin
    // NOTE: default assignment first, so no path leaves cpu_stall unassigned
    // and no latch is inferred.
    cpu_stall = 1'b0;
    case (state)
      IDLE:    cpu_stall = reqGood;
      RD:      cpu_stall = 1'b1;
      WR:      cpu_stall = 1'b1;
      default: cpu_stall = 1'b0;
    endcase
`ifdef DMEM_WBUF_EN
    // A store from IDLE is posted and retires at once; while the buffer
    // drains only a request that needs the bus has to wait.
    if (state == IDLE && cpu_wr_en) cpu_stall = 1'b0;
    if (state == WR)                cpu_stall = reqGood;
`endif
    // Reset abandons the access; release the CPU immediately.
    if (rst) cpu_stall = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the datapath registers are reset along with the control state
      // because every output has to read 0 while and after reset is applied.
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      mem_err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cpu_rdata <= '0;
          if (reqBad) begin
            mem_err <= 1'b1;
          end else if (reqGood) begin
            mem_req   <= 1'b1;
            mem_we    <= cpu_wr_en;
            mem_addr  <= {cpu_addr[ADDR_W-1:2], ALIGN_MASK};
            mem_wdata <= cpu_wdata;
            state     <= cpu_wr_en ? WR : RD;
          end
        end

        RD, WR: begin
          // An ack in the last allowed cycle still completes the transfer.
          if (mem_ack || timerTc) begin
            mem_req <= 1'b0;
            state   <= DONE;
`ifdef DMEM_WBUF_EN
            // A drained posted write has no CPU instruction left to retire.
            if (state == WR) state <= IDLE;
`endif
          end
          if (mem_ack) begin
            if (state == RD) cpu_rdata <= mem_rdata;
          end else if (timerTc) begin
            mem_err   <= 1'b1;
            cpu_rdata <= '0;
          end
`ifdef DMEM_WBUF_EN
          // The CPU is not stalled for a refused request during a drain,
          // so it retires now and must be flagged now.
          if (state == WR && reqBad) mem_err <= 1'b1;
`endif
        end

        DONE: begin
          // The CPU retires on this edge; never reissue the same request.
          cpu_rdata <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl. A behavioural memory answers bus
// requests with a per-transfer ack delay; a reference model predicts stall
// cycles, load data and the sticky error flag from the access rules alone.
// A second instance with TIMEOUT=4 and no ack exercises the bus timeout.
// ----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam int TIMEOUT = 8;
  localparam int BIG     = 1 << 30;
`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic        cpu_rd_en = 1'b0;
  logic        cpu_wr_en = 1'b0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  // Timeout instance signals.
  logic [31:0] tAddr = '0;
  logic        tRdEn = 1'b0;
  logic [31:0] tRdata;
  logic        tStall, tErr, tReq, tWe;
  logic [31:0] tMemAddr, tMemWdata;
  logic        tAck = 1'b0;
  logic [31:0] tMemRdata = 32'hFFFF_FFFF;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .mem_err(mem_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  dmem_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dutTo (
    .clk(clk), .rst(rst),
    .cpu_addr(tAddr), .cpu_wdata(32'h0),
    .cpu_rd_en(tRdEn), .cpu_wr_en(1'b0),
    .cpu_rdata(tRdata), .cpu_stall(tStall), .mem_err(tErr),
    .mem_req(tReq), .mem_we(tWe), .mem_addr(tMemAddr),
    .mem_wdata(tMemWdata), .mem_ack(tAck), .mem_rdata(tMemRdata)
  );

  // ---------------- bookkeeping ----------------
  int nChecks = 0;
  int nPass   = 0;
  int cycle   = 0;

  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic int minInt(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // ---------------- behavioural memory ----------------
  logic [31:0] memArr [logic [31:0]];
  int          delayQ[$];
  int          reqCnt = 0, curDelay = 0, xfers = 0, unstable = 0;
  bit          lateAck = 1'b0;
  logic        holdWe;
  logic [31:0] holdAddr, holdWdata;

  initial begin
    forever begin
      @(negedge clk); #1;
      if (mem_req) begin
        if (reqCnt == 0) begin
          curDelay  = (delayQ.size() > 0) ? delayQ.pop_front() : 0;
          holdWe    = mem_we;
          holdAddr  = mem_addr;
          holdWdata = mem_wdata;
        end else if (mem_we !== holdWe || mem_addr !== holdAddr || mem_wdata !== holdWdata) begin
          unstable++;
        end
        if (reqCnt == curDelay) begin
          mem_ack = 1'b1;
          xfers++;
          if (mem_we) memArr[mem_addr] = mem_wdata;
          else        mem_rdata = memArr.exists(mem_addr) ? memArr[mem_addr] : 32'h0;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        reqCnt++;
      end else begin
        // Acks without a request must be ignored, so throw some in.
        reqCnt    = 0;
        mem_ack   = lateAck | 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] refMem [logic [31:0]];
  int          busyUntil = 0;   // first cycle the controller is idle again
  int          errFrom   = BIG; // first cycle mem_err must read 1
  int          expXfers  = 0;

  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int delay);
    bit          bad, good, tmo;
    int          c, s, r, expStall, stalls;
    logic [31:0] expData, gotData;
    bad  = (rd || wr) && ((addr[1:0] != 2'b00) || (rd && wr));
    good = (rd || wr) && !bad;
    tmo  = good && (delay >= TIMEOUT);
    if (good) delayQ.push_back(delay);
    @(negedge clk);
    cpu_rd_en = rd; cpu_wr_en = wr; cpu_addr = addr; cpu_wdata = wdata;
    c = cycle; expStall = 0; expData = '0;
    if (bad) begin
      errFrom = minInt(errFrom, c + 1);
    end else if (good) begin
      s = (busyUntil > c) ? busyUntil : c;
      r = tmo ? TIMEOUT : delay + 1;   // request cycles on the bus
      if (wr && WBUF) begin
        expStall  = s - c;
        busyUntil = s + r + 1;
      end else begin
        expStall  = s - c + 1 + r;     // idle cycle + request cycles
        busyUntil = s + r + 2;         // then DONE, then idle
      end
      if (tmo) errFrom = minInt(errFrom, s + r + 1);
      else begin
        expXfers++;
        if (wr) refMem[addr] = wdata;
        else    expData = refMem.exists(addr) ? refMem[addr] : 32'h0;
      end
    end
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (!cpu_stall) break;
      stalls++;
      @(negedge clk);
    end
    gotData = cpu_rdata;
    check({tag, "_stall"}, stalls, expStall);
    check({tag, "_rdata"}, gotData, expData);
    @(posedge clk); #1;
    check({tag, "_err"}, mem_err, (cycle >= errFrom));
    cpu_rd_en = 1'b0; cpu_wr_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  int          x0, k, tStalls, tReqCycles;
  logic [31:0] a, tData;

  initial begin
    memArr[32'h10] = 32'hDEAD_BEEF;
    refMem[32'h10] = 32'hDEAD_BEEF;

    repeat (3) @(negedge clk);
    #1;
    check("rst_stall", cpu_stall, 0);
    check("rst_req",   mem_req,   0);
    check("rst_err",   mem_err,   0);
    check("rst_bus",   {mem_we, mem_addr, mem_wdata}, 0);
    rst = 1'b0;
    @(negedge clk); #1;
    check("post_rst_rdata", cpu_rdata, 0);

    // Directed accesses.
    access("rd10", 1, 0, 32'h10, 32'h0, 0);
    x0 = xfers;
    access("wr20", 0, 1, 32'h20, 32'h1234_5678, 5);
    repeat (12) @(negedge clk);
    check("wr20_xfers", xfers - x0, 1);
    access("rd20", 1, 0, 32'h20, 32'h0, 2);
    x0 = xfers;
    access("rd13", 1, 0, 32'h13, 32'h0, 0);
    #1;
    check("rd13_noreq", {mem_req, 32'(xfers - x0)}, 0);
    access("rdlast", 1, 0, 32'h10, 32'h0, TIMEOUT - 1);   // ack in last cycle
    access("rdtmo",  1, 0, 32'h20, 32'h0, TIMEOUT);       // one cycle too late
    access("both",   1, 1, 32'h24, 32'h5, 0);

    // Randomised traffic.
    for (int i = 0; i < 80; i++) begin
      k = $urandom_range(0, 9);
      a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      case (k)
        0, 1, 2, 3: access("rnd_rd", 1, 0, a, 32'h0, $urandom_range(0, TIMEOUT + 2));
        4, 5, 6:    access("rnd_wr", 0, 1, a, $urandom, $urandom_range(0, TIMEOUT + 2));
        7:          access("rnd_mis", k[0], !k[0], a | 32'($urandom_range(1, 3)), $urandom, 0);
        8:          access("rnd_both", 1, 1, a, $urandom, 0);
        default:    access("rnd_none", 0, 0, a, 32'h0, 0);
      endcase
    end
    repeat (20) @(negedge clk);
    check("xfers_total", xfers, expXfers);
    check("req_stable", unstable, 0);

    // Reset in the middle of a write wait.
    delayQ.push_back(100);
    @(negedge clk);
    cpu_wr_en = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    #2;
    check("mid_wr_req", {mem_req, mem_we}, 2'b11);
    rst = 1'b1;
    #1;
    check("rst_mid_req",   mem_req,   0);
    check("rst_mid_stall", cpu_stall, 0);
    cpu_wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    delayQ.delete();
    busyUntil = 0; errFrom = BIG;
    x0 = xfers;
    lateAck = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    lateAck = 1'b0;
    check("late_ack_ignored", {mem_req, cpu_stall, mem_err, 32'(xfers - x0)}, 0);
    access("after_rst_rd", 1, 0, 32'h10, 32'h0, 0);
    access("abandoned_wr", 1, 0, 32'h40, 32'h0, 1);

    // Write immediately followed by a read of the same word.
    access("wb_wr", 0, 1, 32'h44, 32'hA5A5_0F0F, 3);
    access("wb_rd", 1, 0, 32'h44, 32'h0, 0);

    // Timeout instance: TIMEOUT=4, memory never acks.
    @(negedge clk);
    tRdEn = 1'b1; tAddr = 32'h30;
    tStalls = 0; tReqCycles = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (tReq) tReqCycles++;
      if (!tStall) break;
      tStalls++;
      @(negedge clk);
    end
    tData = tRdata;
    check("to_req_cycles", tReqCycles, 4);
    check("to_stall",      tStalls,    5);
    check("to_rdata",      tData,      0);
    @(posedge clk); #1;
    tRdEn = 1'b0;
    check("to_err", {tErr, tReq}, 2'b10);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller placed directly downstream of the single-cycle CPU's memory port.
- Consumes the CPU's ALU address, store data and read/write enables, and returns load data.
- Turns each CPU access into a req/ack handshake on a variable-latency backing memory and stalls the CPU until the access completes.
- Adds alignment checking, a bus timeout and a sticky error flag.

Parameters:
- ADDR_W, 32, width of CPU and memory byte addresses.
- DATA_W, 32, word width.
- TIMEOUT, 255, maximum wait cycles for mem_ack before the access is aborted (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_addr  in  ADDR_W  byte address from the CPU ALU result.
- cpu_wdata  in  DATA_W  store data from register read port 1.
- cpu_rd_en  in  1  load request.
- cpu_wr_en  in  1  store request.
- cpu_rdata  out  DATA_W  load data back to the CPU memToReg mux.
- cpu_stall  out  1  CPU must hold PC and all request inputs stable while high.
- mem_err  out  1  sticky error flag; cleared only by rst.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  word-aligned address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_ack  in  1  memory completion strobe.
- mem_rdata  in  DATA_W  read data; valid in the cycle mem_ack is high.

Behaviour:
- Reset (async, asserted): state IDLE; every output and internal register cleared to 0; mem_req drops immediately. Reset mid-transaction abandons the access with no retry.
- States: IDLE, RD, WR, DONE.
- IDLE, no enable: cpu_stall=0, cpu_rdata=0.
- IDLE, misaligned access (cpu_addr[1:0]≠0 with either enable): no bus cycle, mem_err←1, cpu_rdata=0, cpu_stall=0, remain IDLE.
- IDLE, cpu_rd_en && cpu_wr_en: illegal. Treat as misaligned: mem_err←1, no bus cycle.
- IDLE, valid read or write: cpu_stall=1 combinationally in the same cycle. Latch addr/wdata. Next state RD or WR.
- RD/WR: mem_req=1, with mem_we/mem_addr/mem_wdata from the latched values, held stable until the handshake completes.
  - A transfer completes in the cycle mem_req && mem_ack. On a read, capture mem_rdata. Next state DONE.
  - mem_ack while mem_req=0 is ignored.
- Timeout: a cycle counter clears on entry to RD/WR and increments each cycle without ack. When it reaches TIMEOUT: mem_req drops, mem_err←1, read data captured as 0, next state DONE.
- DONE: cpu_stall=0, cpu_rdata = captured data (0 for writes). The CPU retires the instruction at this edge; next state IDLE unconditionally, so the same request is never reissued.
- Latency: read/write with ack in the first req cycle takes 3 cycles (IDLE, RD/WR, DONE), i.e. the CPU stalls 2 cycles. Each extra wait cycle adds 1.

Optional Feature:
- Macro: DMEM_WBUF_EN.
- When defined:
  - Adds a one-entry posted-write buffer. A write in IDLE with the buffer empty is captured with cpu_stall=0 and drains through WR in the background; no DONE cycle is spent on the CPU side.
  - A read, or a second write, while the buffer is occupied stalls until the drain completes, then proceeds normally.
  - A timeout during a drain sets mem_err and frees the buffer.
- When undefined: writes are blocking exactly as in Behaviour, and no buffer logic exists.

Decomposition:
- Package dmem_pkg holds:
  - the state enum (IDLE, RD, WR, DONE);
  - the alignment mask constant (2'b00);
  - the default TIMEOUT and the DATA_W/ADDR_W defaults.
- One sub-module, dmem_timer: a parameterised clear/enable counter with terminal-count output, used for the timeout.

Test Plan:
- Aligned read at 0x0000_0010, memory acks in the first req cycle with 0xDEAD_BEEF → cpu_stall high for 2 cycles, cpu_rdata=0xDEAD_BEEF in DONE, mem_err=0.
- Write 0x1234_5678 to 0x20, ack delayed 5 cycles → mem_req/mem_we/mem_addr/mem_wdata stable throughout, stall for 7 cycles, single transfer observed.
- Read at 0x0000_0013 → no mem_req, mem_err=1 next cycle, cpu_stall stays 0; mem_err stays 1 over later good accesses.
- Read with TIMEOUT=4 and no ack → mem_req drops after 4 req cycles, mem_err=1, cpu_rdata=0 in DONE.
- Assert rst in the middle of a WR wait → mem_req=0 and cpu_stall=0 immediately, state IDLE; a late mem_ack is ignored.
- With DMEM_WBUF_EN: write then immediate read, ack after 3 cycles → no stall on the write, the read stalls until the drain plus its own access completes, and returns the correct data.
